// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and address helpers for the L1 data cache.
// Address layout: [31:9] tag, [8:5] index, [4:2] word select, [1:0] byte offset.
package dcache_pkg;
    localparam int NUM_LINES  = 16;
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int BLOCK_BITS = 256;
    localparam int OFF_W      = $clog2(BLOCK_BITS / 8);
    localparam int TAG_W      = 32 - IDX_W - OFF_W;
    localparam int WSEL_W     = OFF_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        REFILL,
        REFILL_DONE
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [WSEL_W-1:0] wsel;
        logic [1:0]        byte_off;
    } addr_t;

    function automatic addr_t split_addr(input logic [31:0] addr);
        return addr_t'(addr);
    endfunction

    function automatic logic [31:0] block_addr(input logic [TAG_W-1:0] tag,
                                               input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction
endpackage

// File: rtl/dcache_sram.sv
// Tag/state/data arrays: combinational read by index, full-line refill and word store writes.
// Latency: read 0 cycles, writes land at the clock edge; no backpressure (always accepts).
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [BLOCK_BITS-1:0] rd_data,
    input  logic                  line_we,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic [BLOCK_BITS-1:0] line_data,
    input  logic                  word_we,
    input  logic [WSEL_W-1:0]     word_sel,
    input  logic [31:0]           word_data
);
    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [BLOCK_BITS-1:0] data_q [NUM_LINES];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tags and data carry no reset; valid_q gates every use of them.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_q[idx]  <= line_tag;
            data_q[idx] <= line_data;
        end else if (word_we) begin
            data_q[idx][{word_sel, 5'b0} +: 32] <= word_data;
        end
    end
endmodule

// File: rtl/dcache_stall_ctrl.sv
// Direct-mapped write-back L1 D-cache controller; hits complete with zero added latency.
// Misses stall the pipeline 3 cycles + memory latency (plus one write-back handshake if dirty).
module dcache_stall_ctrl
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_write_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [31:0]           cpu_data_i,
    output logic [31:0]           cpu_data_o,
    output logic                  cpu_stall_o,
    output logic                  mem_req_o,
    output logic                  mem_write_o,
    output logic [31:0]           mem_addr_o,
    output logic [BLOCK_BITS-1:0] mem_data_o,
    input  logic [BLOCK_BITS-1:0] mem_data_i,
    input  logic                  mem_ack_i
);
    state_t                state_q, state_d;
    addr_t                 req_a;
    logic [1:0]            unused_byte;
    logic                  line_valid, line_dirty;
    logic [TAG_W-1:0]      line_tag;
    logic [BLOCK_BITS-1:0] line_data;
    logic                  hit, idle_hit, store_hit, refill_we;

    assign req_a       = split_addr(cpu_addr_i);
    assign unused_byte = req_a.byte_off;

    assign hit       = cpu_req_i && line_valid && (line_tag == req_a.tag);
    assign idle_hit  = (state_q == IDLE) && hit;
    assign store_hit = idle_hit && cpu_write_i;
    assign refill_we = (state_q == REFILL) && mem_ack_i;

    dcache_sram u_sram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .idx       (req_a.idx),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .line_we   (refill_we),
        .line_tag  (req_a.tag),
        .line_data (mem_data_i),
        .word_we   (store_hit),
        .word_sel  (req_a.wsel),
        .word_data (cpu_data_i)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // The CPU holds its inputs during a stall, so req_a still names the missing line.
    always_comb begin
        state_d     = state_q;
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i && !hit) state_d = MISS;
            end
            MISS: begin
                state_d = (line_valid && line_dirty) ? WRITEBACK : REFILL;
            end
            WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = block_addr(line_tag, req_a.idx);
                mem_data_o  = line_data;
                if (mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = block_addr(req_a.tag, req_a.idx);
                if (mem_ack_i) state_d = REFILL_DONE;
            end
            REFILL_DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_stall_o = cpu_req_i && !idle_hit;
    assign cpu_data_o  = (idle_hit && !cpu_write_i) ? line_data[{req_a.wsel, 5'b0} +: 32] : 32'h0;
endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Directed bench for dcache_stall_ctrl with a latency-programmable block memory model.
// Expected memory transactions are queued at stimulus time and compared on each ack.
module tb_dcache_stall_ctrl;
    import dcache_pkg::*;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [255:0] data;
    } txn_t;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         cpu_req_i = 1'b0;
    logic         cpu_write_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    txn_t         exp_q[$];
    logic [255:0] mem_blk [logic [31:0]];
    int           errors = 0;
    int           checks = 0;
    int           hs = 0;
    int           mem_lat = 10;
    int           cnt = 0;
    logic         saw_write = 1'b0;

    dcache_stall_ctrl u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_write_i (cpu_write_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory: acks each request after mem_lat cycles with a one-cycle pulse.
    always begin : mem_model
        txn_t t;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        if (rst_i || !mem_req_o) begin
            cnt = 0;
        end else begin
            if (mem_write_o) saw_write = 1'b1;
            cnt++;
            if (cnt >= mem_lat) begin
                cnt = 0;
                hs++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_txn: observed wr=%0b addr=%0h expected none",
                           mem_write_o, mem_addr_o);
                end else begin
                    t = exp_q.pop_front();
                    check("mem_write", {255'h0, mem_write_o}, {255'h0, t.wr});
                    check("mem_addr", {224'h0, mem_addr_o}, {224'h0, t.addr});
                    if (t.wr) begin
                        check("wb_data", mem_data_o, t.data);
                        mem_blk[mem_addr_o] = mem_data_o;
                    end else begin
                        mem_data_i = mem_blk.exists(mem_addr_o) ? mem_blk[mem_addr_o] : '0;
                    end
                end
                mem_ack_i = 1'b1;
            end
        end
    end

    // One CPU access held until the stall clears; returns the number of stalled cycles.
    task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_stall,
                          input logic [31:0] exp_rd, output int cyc);
        @(negedge clk_i);
        cpu_req_i   = 1'b1;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_data_i  = wdata;
        #1;
        check({tag, "_stall_first"}, {255'h0, cpu_stall_o}, {255'h0, exp_stall});
        check({tag, "_req_first"}, {255'h0, mem_req_o}, 256'h0);
        cyc = 0;
        while (cpu_stall_o && cyc < 200) begin
            @(negedge clk_i);
            #1;
            cyc++;
        end
        check({tag, "_stall_bounded"}, {255'h0, cyc < 200}, 256'h1);
        check({tag, "_data"}, {224'h0, cpu_data_o}, {224'h0, exp_rd});
        @(negedge clk_i);
        cpu_req_i   = 1'b0;
        cpu_write_i = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int           cyc;
        int           hs0;
        logic [255:0] b40, b240, b440, wb;

        b40 = '0;  b40[31:0]  = 32'hDEAD_BEEF; b40[63:32] = 32'h0BAD_F00D;
        b240 = '0; b240[31:0] = 32'hCAFE_0240; b240[255:224] = 32'h7777_0240;
        b440 = '0; b440[31:0] = 32'h0440_0440;
        mem_blk[32'h40]  = b40;
        mem_blk[32'h240] = b240;
        mem_blk[32'h440] = b440;

        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_stall", {255'h0, cpu_stall_o}, 256'h0);
        check("rst_req", {255'h0, mem_req_o}, 256'h0);
        check("rst_write", {255'h0, mem_write_o}, 256'h0);
        check("rst_addr", {224'h0, mem_addr_o}, 256'h0);
        check("rst_wdata", mem_data_o, 256'h0);
        check("rst_rdata", {224'h0, cpu_data_o}, 256'h0);
        check("rst_state", {253'h0, u_dut.state_q}, {253'h0, IDLE});
        check("rst_valid", {240'h0, u_dut.u_sram.valid_q}, 256'h0);
        check("rst_dirty", {240'h0, u_dut.u_sram.dirty_q}, 256'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Cold load miss: clean fetch, 3 + latency stall cycles
        hs0 = hs;
        exp_q.push_back('{1'b0, 32'h40, 256'h0});
        access("cold", 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEAD_BEEF, cyc);
        check("cold_latency", cyc, 13);
        check("cold_handshakes", hs - hs0, 1);

        // Repeat load hit
        hs0 = hs;
        access("hit", 1'b0, 32'h40, 32'h0, 1'b0, 32'hDEAD_BEEF, cyc);
        check("hit_latency", cyc, 0);
        check("hit_handshakes", hs - hs0, 0);

        // Store hit then load back
        hs0 = hs;
        access("st", 1'b1, 32'h44, 32'h1234_5678, 1'b0, 32'h0, cyc);
        check("st_latency", cyc, 0);
        access("ld44", 1'b0, 32'h44, 32'h0, 1'b0, 32'h1234_5678, cyc);
        check("st_handshakes", hs - hs0, 0);
        check("st_dirty2", {255'h0, u_dut.u_sram.dirty_q[2]}, 256'h1);

        // Conflict miss on dirty line: write-back then fetch
        hs0 = hs;
        wb = b40;
        wb[63:32] = 32'h1234_5678;
        exp_q.push_back('{1'b1, 32'h40, wb});
        exp_q.push_back('{1'b0, 32'h240, 256'h0});
        access("dirty", 1'b0, 32'h240, 32'h0, 1'b1, 32'hCAFE_0240, cyc);
        check("dirty_latency", cyc, 23);
        check("dirty_handshakes", hs - hs0, 2);
        check("dirty_cleared", {255'h0, u_dut.u_sram.dirty_q[2]}, 256'h0);
        access("ld25c", 1'b0, 32'h25C, 32'h0, 1'b0, 32'h7777_0240, cyc);

        // Conflict miss on clean line: no write-back
        hs0 = hs;
        saw_write = 1'b0;
        exp_q.push_back('{1'b0, 32'h440, 256'h0});
        access("clean", 1'b0, 32'h440, 32'h0, 1'b1, 32'h0440_0440, cyc);
        check("clean_latency", cyc, 13);
        check("clean_handshakes", hs - hs0, 1);
        check("clean_no_write", {255'h0, saw_write}, 256'h0);

        // Reset during the refill wait
        @(negedge clk_i);
        cpu_req_i   = 1'b1;
        cpu_write_i = 1'b0;
        cpu_addr_i  = 32'h80;
        repeat (4) @(negedge clk_i);
        #1;
        check("mid_in_refill", {255'h0, mem_req_o}, 256'h1);
        rst_i     = 1'b1;
        cpu_req_i = 1'b0;
        #1;
        check("mid_rst_req", {255'h0, mem_req_o}, 256'h0);
        check("mid_rst_stall", {255'h0, cpu_stall_o}, 256'h0);
        check("mid_rst_state", {253'h0, u_dut.state_q}, {253'h0, IDLE});
        check("mid_rst_valid", {240'h0, u_dut.u_sram.valid_q}, 256'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        hs0 = hs;
        exp_q.push_back('{1'b0, 32'h40, 256'h0});
        access("post_rst", 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEAD_BEEF, cyc);
        check("post_rst_latency", cyc, 13);
        check("post_rst_handshakes", hs - hs0, 1);

        repeat (3) @(negedge clk_i);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcache_stall_ctrl.md
Name: dcache_stall_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller sitting between the MEM stage and the off-chip data memory.
- Generates the memory-stall signal consumed by every pipeline register: they freeze while it is high and update normally while it is low.
- Serves hits with zero added latency.
- On a miss, runs write-back and refill transactions against a request/ack memory port.

Parameters:
- NUM_LINES, 16, cache lines. Power of two; index width IDX_W = log2(NUM_LINES) = 4.
- BLOCK_BITS, 256, line size in bits (32 bytes); offset width OFF_W = 5.
- TAG_W, 32-IDX_W-OFF_W = 23, stored tag width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- cpu_req_i  in  1  access request (MemRead or MemWrite of the MEM stage).
- cpu_write_i  in  1  1 = store, 0 = load; valid only with cpu_req_i.
- cpu_addr_i  in  32  byte address. Fields: [31:9] tag, [8:5] index, [4:2] word, [1:0] ignored.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data.
- cpu_stall_o  out  1  memory stall to the pipeline registers.
- mem_req_o  out  1  memory transaction request.
- mem_write_o  out  1  1 = block write-back, 0 = block fetch.
- mem_addr_o  out  32  block-aligned address; [4:0] = 0.
- mem_data_o  out  256  write-back block.
- mem_data_i  in  256  fetched block.
- mem_ack_i  in  1  one-cycle completion pulse from memory.

Behaviour:
- Reset: state = IDLE; all valid and dirty bits cleared; mem_req_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, cpu_data_o = 0, cpu_stall_o = 0. Data and tag arrays are not cleared.
- Hit: cpu_req_i && valid[idx] && tag[idx] == addr tag.
- cpu_stall_o is combinational: cpu_req_i && !(state == IDLE && hit). It rises in the same cycle as the missing request.
- cpu_data_o is combinational: word [4:2] of line idx while state == IDLE and a load hits; otherwise 0.
- The CPU holds all cpu_* inputs stable while cpu_stall_o = 1. The pipeline-freeze protocol guarantees this.
- IDLE:
  - Load hit: data returned in the same cycle; no state change.
  - Store hit: word [4:2] of the line is written at the clock edge; dirty[idx] = 1; no stall.
  - Miss: next state is MISS.
  - No request: stay in IDLE.
- MISS (1 cycle, decision state):
  - If the victim is valid and dirty, go to WRITEBACK.
  - Otherwise go to REFILL.
- WRITEBACK:
  - Outputs: mem_req_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, idx, 5'b0}, mem_data_o = line idx.
  - Outputs are held until mem_ack_i, then go to REFILL.
- REFILL:
  - Outputs: mem_req_o = 1, mem_write_o = 0, mem_addr_o = {req tag, idx, 5'b0}.
  - On mem_ack_i: line idx <= mem_data_i, tag <= req tag, valid = 1, dirty = 0; go to REFILL_DONE.
- REFILL_DONE (1 cycle): mem_req_o = 0; return to IDLE. The held request now hits in IDLE, which releases the stall and completes the load or store.
- mem_req_o deasserts in the cycle after the ack. Memory sees exactly one req..ack handshake per transaction.
- mem_ack_i is ignored in IDLE, MISS and REFILL_DONE.
- Reset asserted mid-transaction: immediate return to IDLE, mem_req_o drops, all lines invalidated. A pending write-back is lost by design; memory must accept an abandoned request.
- cpu_req_i dropping during a stall (only possible under reset or a pipeline flush) does not abort the current transaction. It completes and the line is installed.
- Miss latency:
  - Clean miss: 3 cycles + memory latency.
  - Dirty miss: adds one write-back handshake.

Decomposition:
- Package dcache_pkg: state enum (IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE); IDX_W, OFF_W, TAG_W, BLOCK_BITS constants; address field-slice helpers.
- Sub-module dcache_sram:
  - Arrays: NUM_LINES entries of {valid, dirty, tag} and BLOCK_BITS data.
  - Read is combinational by index.
  - Write ports: full-line write (refill) and single-word write with dirty set (store hit).
  - Valid/dirty are reset asynchronously.
- The controller FSM and hit logic stay in the top module.

Test Plan:
- Cold load of 0x0000_0040 with memory latency 10 and word 0 = 0xDEAD_BEEF → stall rises the same cycle; one fetch at mem_addr_o = 0x40; stall falls after REFILL_DONE; cpu_data_o = 0xDEAD_BEEF.
- Repeat load of 0x0000_0040 → no stall, data returned the same cycle, mem_req_o stays 0.
- Store 0x1234_5678 to 0x0000_0044 (hit), then load 0x0000_0044 → no stall; load returns 0x1234_5678; dirty[2] = 1.
- Load 0x0000_0240 (same index 2, tag 1) → write-back to 0x40 with word 1 = 0x1234_5678, then fetch from 0x240; exactly two req/ack handshakes.
- Load miss on a clean victim → no write-back; mem_write_o never asserted.
- rst_i pulsed during the REFILL wait → state IDLE, mem_req_o = 0, cpu_stall_o = 0; the next access to 0x40 misses.
